result_bcd_formatter: RTL and testbench
=======================================

# result_bcd_formatter

Sequential binary-to-BCD converter at the consumer end of the calculator's arithmetic result interface. It accepts a signed 28-bit result with its valid and overflow flags, as produced by the factorial and other operation units. It converts the magnitude to 8 packed BCD digits using iterative shift-add-3 (double dabble), one bit per cycle, and presents digits, sign and error flags to the 7-segment display driver with a one-cycle valid pulse.

## Interface
- `WIDTH`, 28 — input result width; two's complement, including the sign bit.
- `DIGITS`, 8 — number of BCD output digits.
- `MAX_VAL`, 99_999_999 — largest displayable magnitude.
- `clk`  in  1  — system clock; all state changes on its rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `valid_in`  in  1  — single-cycle strobe marking `d_in`/`ovrflow_in` valid.
- `d_in`  in  WIDTH  — signed result.
- `ovrflow_in`  in  1  — upstream overflow flag; forces the error display.
- `bcd_out`  out  4*DIGITS  — packed BCD, digit 0 in bits [3:0].
- `neg_out`  out  1  — result was negative; the display shows a minus sign.
- `err_out`  out  1  — error: upstream overflow or magnitude > `MAX_VAL`.
- `valid_out`  out  1  — one-cycle pulse; outputs updated this cycle.
- `busy`  out  1  — conversion in progress; `valid_in` is ignored while high.

## Operation
- States: IDLE, SHIFT, DONE. Reset forces IDLE.
- **IDLE**
  - On `valid_in`, capture the magnitude (`-d_in` if `d_in[WIDTH-1]`, else `d_in`) into the shift register, clear the BCD accumulator and bit counter, and latch the sign.
  - Error case: if `ovrflow_in`=1, or the magnitude exceeds `MAX_VAL`, load the accumulator with all digits 4'hE, set the pending error, and go to DONE.
  - Otherwise go to SHIFT.
  - When `ovrflow_in`=1, the sign is forced to 0.
- **SHIFT**
  - Each cycle: add 3 to every accumulator digit that is ≥5, then shift {accumulator, shift register} left by 1. Increment the counter.
  - After WIDTH shifts, go to DONE.
- **DONE**
  - Register the accumulator into `bcd_out`, the sign into `neg_out` and the error into `err_out`.
  - Pulse `valid_out`, return to IDLE.
- Arithmetic and width rules:
  - The magnitude is computed in WIDTH+1 bits, so -2^27 yields 134,217,728 and takes the error case.
  - `d_in`=0 converts normally to all-zero digits.
- Holding and dropping:
  - Outputs hold their last value between conversions.
  - A `valid_in` while `busy`=1 is dropped silently; no queueing.
- Reset mid-operation aborts the conversion. No `valid_out` is produced for the aborted request.

## Timing
- Reset values: `bcd_out`=0, `neg_out`=0, `err_out`=0, `valid_out`=0, `busy`=0.
- Normal path:
  - `valid_in` sampled at edge E0; shifts occur at E1..E28.
  - Outputs and `valid_out` are registered at E29; `valid_out` is high for exactly the cycle after E29.
  - Latency: 29 clocks.
- Error path: outputs are registered at E1; `valid_out` is high the cycle after E1. Latency: 1 clock.
- `busy` is high from after E0 until the edge that asserts `valid_out`, i.e. while the state is SHIFT or DONE.
- The earliest next accepted `valid_in` is at the edge after the one asserting `valid_out`. A `valid_in` coincident with the DONE edge is dropped.
- Back-to-back throughput: one conversion per 30 clocks.

## Configuration
- `RESULT_BCD_BLANK_EN` defined: after conversion, leading zero digits are replaced by 4'hF (blank code for the display driver).
  - Digit 0 is never blanked, so a zero result shows a single "0".
  - Error digits (4'hE) are unaffected.
  - Blanking is applied in the DONE cycle; latency is unchanged.
- Not defined: leading zeros are output as 4'h0.

## Test plan
- `d_in`=120, `valid_in` pulse → 29 clocks later `valid_out`=1, `bcd_out`=32'h0000_0120 (32'hFFFF_F120 with the macro), `neg_out`=0, `err_out`=0.
- `d_in`=99_999_999 → `bcd_out`=32'h9999_9999, `err_out`=0. `d_in`=100_000_000 → after 1 clock, `bcd_out`=32'hEEEE_EEEE, `err_out`=1.
- `ovrflow_in`=1, `d_in`=28'hFFF_FFFF → after 1 clock, `bcd_out`=32'hEEEE_EEEE, `err_out`=1, `neg_out`=0.
- `d_in`=-5 → `neg_out`=1, `bcd_out`=32'h0000_0005. `d_in`=-2^27 → `err_out`=1.
- `valid_in` with 720, then `valid_in` with 6 ten cycles later → only one `valid_out`, `bcd_out`=32'h0000_0720. A 6 sent after `busy` falls → `bcd_out`=32'h0000_0006.
- `rst` pulsed at cycle 10 of a conversion → all outputs 0 immediately. No `valid_out` follows, and a new request completes normally.

Source files
------------

// File: rtl/result_bcd_formatter.sv
// Purpose : signed binary result -> 8 packed BCD digits + sign/error flags for the 7-seg driver.
// Latency : 29 clocks for a normal conversion (28 shift-add-3 steps + DONE), 1 clock on the error path.
// Backpr. : none; valid_in is dropped while busy. Optional RESULT_BCD_BLANK_EN blanks leading zeros (4'hF).
module result_bcd_formatter #(
    parameter int WIDTH   = 28,
    parameter int DIGITS  = 8,
    parameter int MAX_VAL = 99_999_999
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [WIDTH-1:0]      d_in,
    input  logic                  ovrflow_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg_out,
    output logic                  err_out,
    output logic                  valid_out,
    output logic                  busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0]  MAX_MAG  = (WIDTH + 1)'(MAX_VAL);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]            state;
    logic [WIDTH-1:0]      sh_reg;
    logic [4*DIGITS-1:0]   acc;
    logic [CW-1:0]         cnt;
    logic                  neg_q;
    logic                  err_q;

    logic [WIDTH:0]        d_ext;
    logic [WIDTH:0]        mag;
    logic                  too_big;
    logic [4*DIGITS-1:0]   acc_adj;
    logic [4*DIGITS-1:0]   acc_disp;

    // Magnitude in WIDTH+1 bits so the most negative input does not wrap back to itself.
    always_comb begin
        d_ext   = {d_in[WIDTH-1], d_in};
        mag     = d_in[WIDTH-1] ? (~d_ext + 1'b1) : d_ext;
        too_big = (mag > MAX_MAG);
    end

    // Double-dabble correction: any digit >= 5 gets +3 before the next left shift.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Display digits: optionally blank leading zeros, never digit 0; 4'hE digits are nonzero so untouched.
    always_comb begin
        acc_disp = acc;
`ifdef RESULT_BCD_BLANK_EN
        begin : blank_leading
            logic seen_nz;
            seen_nz = 1'b0;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (acc[4*i +: 4] != 4'd0) begin
                    seen_nz = 1'b1;
                end
                if (!seen_nz) begin
                    acc_disp[4*i +: 4] = 4'hF;
                end
            end
        end
`endif
    end

    assign busy = (state == S_SHIFT) || (state == S_DONE);

    // Control FSM, conversion datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            sh_reg    <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            err_q     <= 1'b0;
            bcd_out   <= '0;
            neg_out   <= 1'b0;
            err_out   <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_in) begin
                        sh_reg <= mag[WIDTH-1:0];
                        cnt    <= '0;
                        neg_q  <= d_in[WIDTH-1] & ~ovrflow_in;
                        if (ovrflow_in || too_big) begin
                            acc   <= {DIGITS{4'hE}};
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            acc   <= '0;
                            err_q <= 1'b0;
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    acc    <= {acc_adj[4*DIGITS-2:0], sh_reg[WIDTH-1]};
                    sh_reg <= {sh_reg[WIDTH-2:0], 1'b0};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    bcd_out   <= acc_disp;
                    neg_out   <= neg_q;
                    err_out   <= err_q;
                    valid_out <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_bcd_formatter.sv
// Purpose : directed bench for result_bcd_formatter with a decimal-arithmetic reference model.
// Latency : expects valid_out 29 edges after acceptance (1 on the error path).
// Backpr. : models request dropping while a conversion is in flight.
module tb_result_bcd_formatter;

`ifdef RESULT_BCD_BLANK_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [27:0] d_in = '0;
    logic        ovrflow_in = 1'b0;
    logic [31:0] bcd_out;
    logic        neg_out;
    logic        err_out;
    logic        valid_out;
    logic        busy;

    result_bcd_formatter dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .d_in       (d_in),
        .ovrflow_in (ovrflow_in),
        .bcd_out    (bcd_out),
        .neg_out    (neg_out),
        .err_out    (err_out),
        .valid_out  (valid_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bcd;
        logic        neg;
        logic        err;
        int          edge_n;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   ncmp = 0;
    int   nfail = 0;
    int   free_edge = 0;
    int   busy_from = 1000000;
    int   busy_to = -1;
    int   last_e0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: decimal digits by repeated division, blanking by comparing against powers of ten.
    function automatic logic [31:0] model_bcd(input longint mag, input bit err);
        logic [31:0] r;
        longint v;
        longint p;
        if (err) return 32'hEEEE_EEEE;
        r = '0;
        v = mag;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            if (BL && i > 0 && mag < p) r[4*i +: 4] = 4'hF;
            else                        r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
            p = p * 10;
        end
        return r;
    endfunction

    function automatic longint model_mag(input logic [27:0] d);
        longint dv;
        dv = d[27] ? (longint'(d) - (longint'(1) << 28)) : longint'(d);
        return (dv < 0) ? -dv : dv;
    endfunction

    // Per-cycle compare of busy and every valid_out against the model queue.
    always @(negedge clk) begin
        chk("busy", {31'b0, busy}, {31'b0, (cyc >= busy_from && cyc <= busy_to)});
        if (valid_out) begin
            if (q.size() == 0) begin
                chk("spurious_valid_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("latency_edge", cyc, e.edge_n);
                chk("bcd_out", bcd_out, e.bcd);
                chk("neg_out", {31'b0, neg_out}, {31'b0, e.neg});
                chk("err_out", {31'b0, err_out}, {31'b0, e.err});
            end
        end else if (q.size() != 0 && cyc > q[0].edge_n) begin
            chk("missing_valid_out", 32'd0, 32'd1);
            void'(q.pop_front());
        end
    end

    task automatic send(input logic [27:0] d, input logic ov);
        int     e0;
        int     lat;
        longint m;
        exp_t   e;
        @(posedge clk); #2;
        e0 = cyc + 1;
        d_in = d;
        ovrflow_in = ov;
        valid_in = 1'b1;
        last_e0 = e0;
        if (e0 >= free_edge) begin
            m = model_mag(d);
            e.err = ov || (m > 99_999_999);
            e.neg = !ov && d[27];
            e.bcd = model_bcd(m, e.err);
            lat = e.err ? 1 : 29;
            e.edge_n = e0 + lat;
            q.push_back(e);
            busy_from = e0;
            busy_to = e0 + lat - 1;
            free_edge = e0 + lat + 1;
        end
        @(posedge clk); #2;
        valid_in = 1'b0;
        ovrflow_in = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) chk("wait_done_timeout", 32'd1, 32'd0);
        @(negedge clk); #1;
    endtask

    initial begin
        // Model pinned against hand-computed values.
        chk("model_120", model_bcd(120, 0), BL ? 32'hFFFF_F120 : 32'h0000_0120);
        chk("model_0", model_bcd(0, 0), BL ? 32'hFFFF_FFF0 : 32'h0000_0000);
        chk("model_max", model_bcd(model_mag(28'd99_999_999), 0), 32'h9999_9999);
        chk("model_neg5_mag", 32'(model_mag(28'hFFF_FFFB)), 32'd5);
        chk("model_min_mag", 32'(model_mag(28'h800_0000)), 32'd134_217_728);

        // Reset state.
        #12;
        chk("rst_bcd", bcd_out, 32'h0);
        chk("rst_neg", {31'b0, neg_out}, 32'h0);
        chk("rst_err", {31'b0, err_out}, 32'h0);
        chk("rst_valid", {31'b0, valid_out}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;

        send(28'd120, 1'b0);
        wait_done();
        chk("lit_120", bcd_out, BL ? 32'hFFFF_F120 : 32'h0000_0120);

        send(28'd99_999_999, 1'b0);
        wait_done();
        chk("lit_max", bcd_out, 32'h9999_9999);
        chk("lit_max_err", {31'b0, err_out}, 32'h0);

        send(28'd100_000_000, 1'b0);
        wait_done();
        chk("lit_over", bcd_out, 32'hEEEE_EEEE);
        chk("lit_over_err", {31'b0, err_out}, 32'h1);

        send(28'hFFF_FFFF, 1'b1);
        wait_done();
        chk("lit_ovf_neg", {31'b0, neg_out}, 32'h0);
        chk("lit_ovf_err", {31'b0, err_out}, 32'h1);

        send(28'hFFF_FFFB, 1'b0);
        wait_done();
        chk("lit_m5_neg", {31'b0, neg_out}, 32'h1);
        chk("lit_m5", bcd_out, BL ? 32'hFFFF_FFF5 : 32'h0000_0005);

        send(28'h800_0000, 1'b0);
        wait_done();
        chk("lit_min_err", {31'b0, err_out}, 32'h1);

        send(28'd0, 1'b0);
        wait_done();
        chk("lit_zero", bcd_out, BL ? 32'hFFFF_FFF0 : 32'h0000_0000);

        send(28'd7_654_321, 1'b0);
        wait_done();

        // Second request ten cycles into a conversion is dropped.
        send(28'd720, 1'b0);
        repeat (8) @(posedge clk);
        send(28'd6, 1'b0);
        wait_done();
        chk("lit_720", bcd_out, BL ? 32'hFFFF_F720 : 32'h0000_0720);
        send(28'd6, 1'b0);
        wait_done();
        chk("lit_6", bcd_out, BL ? 32'hFFFF_FFF6 : 32'h0000_0006);

        // Request coincident with the DONE edge is dropped.
        send(28'd720, 1'b0);
        while (cyc < last_e0 + 27) begin
            @(posedge clk); #1;
        end
        send(28'd6, 1'b0);
        wait_done();
        chk("lit_done_drop", bcd_out, BL ? 32'hFFFF_F720 : 32'h0000_0720);
        repeat (40) @(posedge clk);

        // Reset mid-conversion aborts it.
        send(28'd12_345_678, 1'b0);
        while (cyc < last_e0 + 10) begin
            @(posedge clk); #2;
        end
        rst = 1'b1;
        q.delete();
        busy_from = 1000000;
        busy_to = -1;
        free_edge = 0;
        #1;
        chk("mid_rst_bcd", bcd_out, 32'h0);
        chk("mid_rst_neg", {31'b0, neg_out}, 32'h0);
        chk("mid_rst_err", {31'b0, err_out}, 32'h0);
        chk("mid_rst_valid", {31'b0, valid_out}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        send(28'd4321, 1'b0);
        wait_done();
        chk("lit_after_rst", bcd_out, BL ? 32'hFFFF_4321 : 32'h0000_4321);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
